// File: rtl/io_uart_txbuf.sv
// UART transmit buffer: circular byte storage feeding a one-byte output register
// that presents data to the UART emitter with a valid/ready handshake.
module io_uart_txbuf #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [7:0]    i_wdata,
  input  logic          i_flush,
  input  logic          i_clr_ovf,
  output logic [7:0]    o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ovf,
  output logic [31:0]   o_status
);

  localparam int PW = $clog2(DEPTH);
  localparam int NS = DEPTH - 1;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_SEND = 1'b1;

  logic          r_state;
  logic [7:0]    r_data;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_scnt;
  logic          r_ovf;
  logic [7:0]    r_mem [0:NS-1];

  logic          w_xfer;
  logic          w_st_empty;
  logic          w_push;
  logic          w_drop;
  logic          w_can_load;
  logic          w_load_head;
  logic          w_load_direct;
  logic          w_st_wr;
  logic          w_st_rd;
  logic [CW-1:0] w_count;
  logic [7:0]    w_cnt8;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(NS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_count    = CW'(r_scnt) + CW'(r_state);
  assign w_cnt8     = 8'(w_count);
  assign w_xfer     = (r_state == S_SEND) & i_ready;
  assign w_st_empty = (r_scnt == '0);

  // Acceptance is judged against the registered full flag, so a same-cycle
  // transfer never frees room for the write.
  assign w_push = i_wr & ~o_full & ~i_flush;
  assign w_drop = i_wr & o_full & ~i_flush;

  assign w_can_load    = (r_state == S_IDLE) | w_xfer;
  assign w_load_head   = w_can_load & ~w_st_empty & ~i_flush;
  assign w_load_direct = w_can_load & w_st_empty & w_push;
  assign w_st_wr       = w_push & ~w_load_direct;
  assign w_st_rd       = w_load_head;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_scnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load_head) begin
        r_data  <= r_mem[r_rptr];
        r_state <= S_SEND;
      end else if (w_load_direct) begin
        r_data  <= i_wdata;
        r_state <= S_SEND;
      end else if (w_xfer) begin
        r_state <= S_IDLE;
      end

      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_scnt <= '0;
      end else begin
        if (w_st_wr) r_wptr <= f_inc(r_wptr);
        if (w_st_rd) r_rptr <= f_inc(r_rptr);
        r_scnt <= r_scnt + PW'(w_st_wr) - PW'(w_st_rd);
      end

      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_st_wr) r_mem[r_wptr] <= i_wdata;
  end

  assign o_data   = r_data;
  assign o_valid  = (r_state == S_SEND);
  assign o_count  = w_count;
  assign o_full   = (w_count == CW'(DEPTH));
  assign o_empty  = (w_count == '0);
  assign o_ovf    = r_ovf;
  assign o_status = {16'b0, w_cnt8, 5'b0, r_ovf, o_full, o_empty};

endmodule

// File: doc/io_uart_txbuf.md
IO_UART_TXBUF -- requirements
Module: io_uart_txbuf

Interface
REQ-001 Parameter DEPTH, default 16: total byte capacity, including the output register; power of two, >= 2.
REQ-002 Parameter CW, default $clog2(DEPTH)+1: width of o_count.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_wr  in  1  CPU IO write strobe for the TX data word; one byte is pushed per cycle it is high.
REQ-006 i_wdata  in  8  byte to push (IO_mem_wdata[7:0]).
REQ-007 i_flush  in  1  discards all queued bytes not yet presented on o_data.
REQ-008 i_clr_ovf  in  1  clears the sticky overflow flag.
REQ-009 o_data  out  8  byte presented to the UART emitter i_data.
REQ-010 o_valid  out  1  o_data is valid; drives the UART emitter i_valid.
REQ-011 i_ready  in  1  UART emitter o_ready; a transfer occurs on a cycle with o_valid && i_ready.
REQ-012 o_count  out  CW  bytes held, storage plus output register, range 0..DEPTH.
REQ-013 o_full  out  1  o_count == DEPTH.
REQ-014 o_empty  out  1  o_count == 0.
REQ-015 o_ovf  out  1  sticky flag: a write was dropped because the buffer was full.
REQ-016 o_status  out  32  IO read word {16'b0, o_count zero-extended to 8 bits, 5'b0, o_ovf, o_full, o_empty}.

Function
REQ-017 Structure: circular storage of DEPTH-1 entries with read/write pointers that wrap modulo DEPTH-1, plus a one-byte output register; all outputs registered or decoded from registers.
REQ-018 Output FSM has two states. S_IDLE has o_valid=0. S_SEND has o_valid=1 and the output register holds the head byte.
REQ-019 S_IDLE -> S_SEND on the edge after a push while storage is empty; the byte loads directly into the output register (1-cycle write-to-o_valid latency).
REQ-020 S_IDLE -> S_SEND also occurs on the edge after storage is found non-empty; the head byte moves into the output register.
REQ-021 In S_SEND on a transfer: if storage is non-empty, or a push arrives in the same cycle, the next byte loads and the FSM stays in S_SEND (back-to-back, no bubble); otherwise S_SEND -> S_IDLE.
REQ-022 Once o_valid=1, o_valid and o_data remain stable until a transfer occurs; neither i_flush nor i_wr alters them.
REQ-023 Push acceptance uses o_full as registered at the start of the cycle; a write while o_full=1 is dropped even if a transfer happens in the same cycle, and o_ovf sets the next cycle.
REQ-024 o_count: +1 on an accepted push only, -1 on a transfer only, unchanged when both occur, never below 0 or above DEPTH.
REQ-025 i_flush empties storage and resets the pointers, and o_count becomes o_valid ? 1 : 0. A push in the same cycle is dropped but does not set o_ovf.
REQ-026 i_clr_ovf clears o_ovf. If a drop and i_clr_ovf occur in the same cycle, o_ovf=1 (set wins).
REQ-027 Byte order at o_data equals push order; no duplication, and no loss except by REQ-023 and REQ-025.

Reset
REQ-028 While i_rst=1: FSM=S_IDLE, pointers=0, o_valid=0, o_data=8'h00, o_count=0, o_empty=1, o_full=0, o_ovf=0, o_status=32'h0000_0001.
REQ-029 i_rst overrides all other inputs, including mid-transfer; queued bytes are lost, and operation resumes on the first cycle after i_rst falls.

Verification
REQ-030 Reset, then push 8'h41 at cycle N with i_ready=0 -> at N+1 o_valid=1, o_data=8'h41, o_count=1; o_data holds for 20 cycles until i_ready=1.
REQ-031 Push "HELLO" on consecutive cycles with i_ready=1 held -> o_data sequence H,E,L,L,O with o_valid continuous, then o_valid=0 and o_count=0.
REQ-032 DEPTH=16, i_ready=0: push 17 bytes 8'h00..8'h10 -> o_full=1 after the 16th push; 8'h10 dropped; o_ovf=1; draining yields 8'h00..8'h0F.
REQ-033 At o_full=1, push 8'hAA concurrent with a transfer -> 8'hAA dropped, o_count=15, o_ovf=1; i_clr_ovf pulse -> o_ovf=0.
REQ-034 Queue 5 bytes with i_ready=0, then pulse i_flush -> o_count=1, the first byte still presented; after its transfer o_valid=0, o_empty=1.
REQ-035 Queue 3 bytes, assert i_rst for 1 cycle mid-stream -> o_valid=0, o_count=0, o_status=32'h0000_0001; a subsequent push of 8'h5A appears 1 cycle later.
